csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MHARTID, default 32'h0, value returned on reads of mhartid (0xF14).
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port timer_irq_i  input  1  level timer interrupt from clint.
REQ-006 SHALL have port instret_i  input  1  one-cycle pulse per retired instruction.
REQ-007 SHALL have ports exu_we_i  input  1,  exu_waddr_i  input  12,  exu_wdata_i  input  32: CSR-instruction write port.
REQ-008 SHALL have ports excp_we_i  input  1,  excp_waddr_i  input  12,  excp_wdata_i  input  32: exception-unit write port.
REQ-009 SHALL have ports raddr_i  input  12,  rdata_o  output  32: CSR-instruction read port.
REQ-010 SHALL have outputs csr_mtvec_o, csr_mepc_o, csr_mstatus_o, each 32: current register values to the exception unit.

Function
REQ-011 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mhartid 0xF14.
REQ-012 SHALL treat writes as taking effect at the clk edge where we is high; new value visible on rdata_o and csr_*_o from the following cycle.
REQ-013 SHALL return rdata_o combinationally from the current register state; a same-cycle write to raddr_i SHALL NOT be bypassed.
REQ-014 SHALL read unmapped addresses as 32'h0 and ignore writes to them.
REQ-015 SHALL make mstatus writable only in MIE[3] and MPIE[7]; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-016 SHALL make mie writable only in MTIE[7]; other bits SHALL read 0.
REQ-017 SHALL read mip as MTIP[7] = timer_irq_i, all other bits 0; writes SHALL be ignored.
REQ-018 SHALL force mtvec[1:0] and mepc[1:0] to 0 on write (direct mode, aligned PC).
REQ-019 SHALL store mcause and mscratch as full 32-bit values.
REQ-020 SHALL make mhartid read-only; writes ignored.
REQ-021 SHALL hold mcycle as a 64-bit counter incrementing by 1 every cycle out of reset, wrapping 64'hFFFF_FFFF_FFFF_FFFF -> 0.
REQ-022 SHALL hold minstret as a 64-bit counter incrementing by 1 on each cycle with instret_i high, same wrap rule.
REQ-023 SHALL, on a write to a counter half, load that half with wdata and hold the other half, with no increment in that cycle; the write overrides the increment.
REQ-024 SHALL, when exu and excp write different addresses in the same cycle, apply both writes.
REQ-025 SHALL, when exu and excp write the same address in the same cycle, apply only the excp value.
REQ-026 SHALL, when exu and excp write the low and high halves of the same counter in the same cycle, apply both halves with no increment.
REQ-027 SHALL drive csr_mstatus_o with the masked value from REQ-015, i.e. identical to a read of 0x300.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear mstatus (reads 32'h0000_1800), mie, mscratch, mepc, mcause, mcycle and minstret to 0, and set mtvec to MTVEC_RST with bits [1:0] cleared.
REQ-029 SHALL hold every counter at 0 while rst_n is low; the first increment SHALL occur at the first clk edge after release.
REQ-030 SHALL, on reset asserted mid-write, discard the write; reset wins.

Verification
REQ-031 Bench SHALL check this case: reset release, read 0x300/0x305/0xB00 on successive cycles -> 32'h1800, MTVEC_RST & ~3, and cycle count rising by 1 per cycle.
REQ-032 Bench SHALL check this case: excp writes 0x341=32'h8000_0107, then 0x300=32'hFFFF_FFFF, then 0x342=32'h8000_0007 -> csr_mepc_o=32'h8000_0104, csr_mstatus_o=32'h1888, mcause read 32'h8000_0007.
REQ-033 Bench SHALL check this case: same-cycle exu 0x340=32'h1111_1111 and excp 0x340=32'h2222_2222 -> mscratch=32'h2222_2222; different addresses -> both land.
REQ-034 Bench SHALL check this case: exu writes 0xB00=32'hFFFF_FFFF and 0xB80=32'hFFFF_FFFF on successive cycles, then waits 1 cycle -> {mcycleh,mcycle} wraps to 0 then 1.
REQ-035 Bench SHALL check this case: timer_irq_i toggled, then exu writes 0x344=32'h0 -> mip reads 32'h80 exactly while irq is high, and the write has no effect.
REQ-036 Bench SHALL check this case: instret_i pulsed 5 times with the exu writing 0xB02=32'h10 on the 3rd pulse -> minstret=32'h12.

Source files
------------

// File: rtl/csr_if.sv
// CSR access bus: two write ports (CSR instruction and exception unit)
// and one combinational read port, shared by the CSR file and its clients.
interface csr_if;
    logic        exu_we_i;
    logic [11:0] exu_waddr_i;
    logic [31:0] exu_wdata_i;
    logic        excp_we_i;
    logic [11:0] excp_waddr_i;
    logic [31:0] excp_wdata_i;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;

    modport master (
        output exu_we_i, exu_waddr_i, exu_wdata_i,
        output excp_we_i, excp_waddr_i, excp_wdata_i,
        output raddr_i,
        input  rdata_o
    );

    modport slave (
        input  exu_we_i, exu_waddr_i, exu_wdata_i,
        input  excp_we_i, excp_waddr_i, excp_wdata_i,
        input  raddr_i,
        output rdata_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: control/status registers, 64-bit cycle and instret
// counters, two prioritised write ports and an unbypassed combinational read.
module csr_file #(
    parameter logic [31:0] MHARTID   = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_irq_i,
    input  logic        instret_i,
    csr_if.slave        bus,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_port_t;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } wr_t;

    // Exception-unit write wins over a CSR-instruction write to the same address.
    function automatic wr_t wr_sel(input wr_port_t exu, input wr_port_t excp,
                                   input logic [11:0] addr);
        wr_t r;
        logic exu_hit;
        logic excp_hit;
        exu_hit  = exu.we  && (exu.addr  == addr);
        excp_hit = excp.we && (excp.addr == addr);
        r.we     = exu_hit || excp_hit;
        r.data   = excp_hit ? excp.data : exu.data;
        return r;
    endfunction

    wr_port_t exu_port;
    wr_port_t excp_port;

    assign exu_port  = '{we: bus.exu_we_i,  addr: bus.exu_waddr_i,  data: bus.exu_wdata_i};
    assign excp_port = '{we: bus.excp_we_i, addr: bus.excp_waddr_i, data: bus.excp_wdata_i};

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic [29:0] mtvec_q,        mtvec_d;
    logic [29:0] mepc_q,         mepc_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [63:0] mcycle_q,       mcycle_d;
    logic [63:0] minstret_q,     minstret_d;

    always_comb begin
        wr_t wr;
        wr_t wr_hi;
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mscratch_d     = mscratch_q;
        mcause_d       = mcause_q;

        wr = wr_sel(exu_port, excp_port, ADDR_MSTATUS);
        if (wr.we) begin
            mstatus_mie_d  = wr.data[3];
            mstatus_mpie_d = wr.data[7];
        end
        wr = wr_sel(exu_port, excp_port, ADDR_MIE);
        if (wr.we) mie_mtie_d = wr.data[7];
        wr = wr_sel(exu_port, excp_port, ADDR_MTVEC);
        if (wr.we) mtvec_d = wr.data[31:2];
        wr = wr_sel(exu_port, excp_port, ADDR_MEPC);
        if (wr.we) mepc_d = wr.data[31:2];
        wr = wr_sel(exu_port, excp_port, ADDR_MSCRATCH);
        if (wr.we) mscratch_d = wr.data;
        wr = wr_sel(exu_port, excp_port, ADDR_MCAUSE);
        if (wr.we) mcause_d = wr.data;

        // A write to either counter half freezes the counter for that cycle.
        wr    = wr_sel(exu_port, excp_port, ADDR_MCYCLE);
        wr_hi = wr_sel(exu_port, excp_port, ADDR_MCYCLEH);
        if (wr.we || wr_hi.we) begin
            mcycle_d = {wr_hi.we ? wr_hi.data : mcycle_q[63:32],
                        wr.we    ? wr.data    : mcycle_q[31:0]};
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end

        wr    = wr_sel(exu_port, excp_port, ADDR_MINSTRET);
        wr_hi = wr_sel(exu_port, excp_port, ADDR_MINSTRH);
        if (wr.we || wr_hi.we) begin
            minstret_d = {wr_hi.we ? wr_hi.data : minstret_q[63:32],
                          wr.we    ? wr.data    : minstret_q[31:0]};
        end else begin
            minstret_d = minstret_q + {63'd0, instret_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST[31:2];
            mepc_q         <= '0;
            mscratch_q     <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mscratch_q     <= mscratch_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    logic [31:0] mstatus_val;
    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

    assign csr_mstatus_o = mstatus_val;
    assign csr_mtvec_o   = {mtvec_q, 2'b00};
    assign csr_mepc_o    = {mepc_q, 2'b00};

    always_comb begin
        unique case (bus.raddr_i)
            ADDR_MSTATUS:  bus.rdata_o = mstatus_val;
            ADDR_MIE:      bus.rdata_o = {24'd0, mie_mtie_q, 7'd0};
            ADDR_MTVEC:    bus.rdata_o = {mtvec_q, 2'b00};
            ADDR_MSCRATCH: bus.rdata_o = mscratch_q;
            ADDR_MEPC:     bus.rdata_o = {mepc_q, 2'b00};
            ADDR_MCAUSE:   bus.rdata_o = mcause_q;
            ADDR_MIP:      bus.rdata_o = {24'd0, timer_irq_i, 7'd0};
            ADDR_MCYCLE:   bus.rdata_o = mcycle_q[31:0];
            ADDR_MCYCLEH:  bus.rdata_o = mcycle_q[63:32];
            ADDR_MINSTRET: bus.rdata_o = minstret_q[31:0];
            ADDR_MINSTRH:  bus.rdata_o = minstret_q[63:32];
            ADDR_MHARTID:  bus.rdata_o = MHARTID;
            default:       bus.rdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: stimulus pushes expected values into a
// scoreboard queue, a negedge monitor pops and compares against the DUT.
module tb_csr_file;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] TVEC = 32'h8000_0103;

    typedef enum int {SRC_RD, SRC_MTVEC, SRC_MEPC, SRC_MSTATUS} src_e;
    typedef struct {
        string       name;
        src_e        src;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic timer_irq;
    logic instret;
    logic [31:0] mtvec_o, mepc_o, mstatus_o;

    csr_if bus ();

    csr_file #(.MHARTID(HART), .MTVEC_RST(TVEC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .timer_irq_i  (timer_irq),
        .instret_i    (instret),
        .bus          (bus),
        .csr_mtvec_o  (mtvec_o),
        .csr_mepc_o   (mepc_o),
        .csr_mstatus_o(mstatus_o)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   chk_n   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < chk_n; i++) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got no entry, required one");
            end else begin
                e = sb.pop_front();
                case (e.src)
                    SRC_MTVEC:   got = mtvec_o;
                    SRC_MEPC:    got = mepc_o;
                    SRC_MSTATUS: got = mstatus_o;
                    default:     got = bus.rdata_o;
                endcase
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", e.name, got, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.exu_we_i  = 1'b0;
        bus.excp_we_i = 1'b0;
        instret       = 1'b0;
        chk_n         = 0;
    endtask

    task automatic exu_wr(input logic [11:0] a, input logic [31:0] d);
        bus.exu_we_i    = 1'b1;
        bus.exu_waddr_i = a;
        bus.exu_wdata_i = d;
    endtask

    task automatic excp_wr(input logic [11:0] a, input logic [31:0] d);
        bus.excp_we_i    = 1'b1;
        bus.excp_waddr_i = a;
        bus.excp_wdata_i = d;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
        bus.raddr_i = a;
        sb.push_back('{name: n, src: SRC_RD, exp: e});
        chk_n++;
    endtask

    task automatic out(input src_e s, input logic [31:0] e, input string n);
        sb.push_back('{name: n, src: s, exp: e});
        chk_n++;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; timer_irq = 1'b0; instret = 1'b0;
        bus.exu_we_i = 1'b0;  bus.exu_waddr_i = '0;  bus.exu_wdata_i = '0;
        bus.excp_we_i = 1'b0; bus.excp_waddr_i = '0; bus.excp_wdata_i = '0;
        bus.raddr_i = '0;
        tick();

        // Reset state, counters held at zero while reset is low
        rd(12'hB00, 32'h0, "rst_mcycle");      out(SRC_MSTATUS, 32'h1800, "rst_mstatus_o"); tick();
        rd(12'h342, 32'h0, "rst_mcause");      out(SRC_MTVEC, 32'h8000_0100, "rst_mtvec_o"); tick();
        rd(12'hB02, 32'h0, "rst_minstret");    out(SRC_MEPC, 32'h0, "rst_mepc_o");           tick();
        rd(12'hB00, 32'h0, "rst_mcycle_hold"); tick();

        // Release: successive reads, cycle count rising by one per cycle
        rst_n = 1'b1;
        rd(12'h300, 32'h1800, "rel_mstatus");     tick();
        rd(12'h305, 32'h8000_0100, "rel_mtvec");  tick();
        rd(12'hB00, 32'd2, "rel_mcycle_2");       tick();
        rd(12'hB00, 32'd3, "rel_mcycle_3");       tick();
        rd(12'hB80, 32'd0, "rel_mcycleh");        tick();
        rd(12'h304, 32'h0, "rst_mie");            tick();
        rd(12'h340, 32'h0, "rst_mscratch");       tick();

        // mhartid is read-only
        rd(12'hF14, HART, "mhartid"); exu_wr(12'hF14, 32'hFFFF_FFFF); tick();
        rd(12'hF14, HART, "mhartid_ro"); tick();

        // Exception-unit write sequence
        excp_wr(12'h341, 32'h8000_0107); tick();
        excp_wr(12'h300, 32'hFFFF_FFFF); out(SRC_MEPC, 32'h8000_0104, "excp_mepc_o"); tick();
        excp_wr(12'h342, 32'h8000_0007); out(SRC_MSTATUS, 32'h0000_1888, "excp_mstatus_o"); tick();
        rd(12'h342, 32'h8000_0007, "excp_mcause"); tick();
        rd(12'h300, 32'h0000_1888, "excp_mstatus_rd"); tick();

        // Field masking
        exu_wr(12'h305, 32'h1234_5677); tick();
        rd(12'h305, 32'h1234_5674, "mtvec_align"); out(SRC_MTVEC, 32'h1234_5674, "mtvec_o_align"); tick();
        exu_wr(12'h304, 32'hFFFF_FFFF); tick();
        rd(12'h304, 32'h0000_0080, "mie_mask"); tick();
        exu_wr(12'h300, 32'h0); tick();
        rd(12'h300, 32'h1800, "mstatus_clear"); out(SRC_MSTATUS, 32'h1800, "mstatus_o_clear"); tick();

        // Unmapped addresses
        exu_wr(12'h123, 32'hFFFF_FFFF); tick();
        rd(12'h123, 32'h0, "unmapped_123"); tick();
        rd(12'h301, 32'h0, "unmapped_301"); tick();

        // Write-port collisions
        exu_wr(12'h340, 32'h1111_1111); excp_wr(12'h340, 32'h2222_2222); tick();
        rd(12'h340, 32'h2222_2222, "same_addr_excp_wins"); tick();
        exu_wr(12'h340, 32'h3333_3333); excp_wr(12'h342, 32'h4444_4444); tick();
        rd(12'h340, 32'h3333_3333, "diff_addr_exu"); tick();
        rd(12'h342, 32'h4444_4444, "diff_addr_excp"); tick();

        // No bypass of a same-cycle write
        exu_wr(12'h340, 32'h5555_5555); rd(12'h340, 32'h3333_3333, "no_bypass"); tick();
        rd(12'h340, 32'h5555_5555, "after_write"); tick();

        // mcycle wrap
        exu_wr(12'hB00, 32'hFFFF_FFFF); tick();
        exu_wr(12'hB80, 32'hFFFF_FFFF); tick();
        rd(12'hB80, 32'hFFFF_FFFF, "wrap_hi_loaded"); tick();
        rd(12'hB00, 32'h0, "wrap_lo_0"); tick();
        rd(12'hB00, 32'h1, "wrap_lo_1"); tick();
        rd(12'hB80, 32'h0, "wrap_hi_0"); tick();

        // Both counter halves in one cycle, no increment
        exu_wr(12'hB00, 32'h0000_0010); excp_wr(12'hB80, 32'h0000_0002); tick();
        rd(12'hB00, 32'h0000_0010, "split_lo"); tick();
        rd(12'hB80, 32'h0000_0002, "split_hi"); tick();

        // mip follows the timer line, writes ignored
        timer_irq = 1'b1; rd(12'h344, 32'h80, "mip_irq_hi"); tick();
        exu_wr(12'h344, 32'h0); rd(12'h344, 32'h80, "mip_write_cycle"); tick();
        rd(12'h344, 32'h80, "mip_write_ignored"); tick();
        timer_irq = 1'b0; rd(12'h344, 32'h0, "mip_irq_lo"); tick();

        // minstret: five pulses, write on the third overrides the increment
        instret = 1'b1; tick();
        instret = 1'b1; tick();
        tick();
        instret = 1'b1; exu_wr(12'hB02, 32'h10); tick();
        instret = 1'b1; tick();
        tick();
        instret = 1'b1; tick();
        rd(12'hB02, 32'h12, "minstret_count"); tick();
        rd(12'hB82, 32'h0, "minstreth"); tick();

        // Reset asserted during a write discards it
        exu_wr(12'h340, 32'hDEAD_BEEF); excp_wr(12'h341, 32'h0000_0444);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        rd(12'h340, 32'h0, "rst_discard_mscratch"); out(SRC_MEPC, 32'h0, "rst_discard_mepc"); tick();
        rd(12'hB00, 32'h1, "rst_first_inc"); out(SRC_MTVEC, 32'h8000_0100, "rst_mtvec_again"); tick();
        tick();

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
